// File: rtl/fp_addsub_pipe_if.sv
// Operand/result streaming bundle for fp_addsub_pipe.
// A beat transfers on any rising edge where valid and ready are both high; a producer holds
// valid and its data unchanged until that edge, and ready may depend combinationally on the far side.
interface fp_addsub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, s, flags
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, s, flags
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 adder/subtractor (align, add/normalise, round/pack) with RNE rounding,
// Inf/NaN bypass and {invalid, overflow, underflow, inexact} flags on a stallable stream.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic             clk,
    input logic             rst_n,
    fp_addsub_pipe_if.slave bus
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int XW = EXP_W + 2;   // signed exponent width, wide enough to never wrap
    localparam int AW = MAN_W + 3;   // aligned smaller operand: hidden, frac, G, R
    localparam int MW = MAN_W + 4;   // normalised mantissa: hidden, frac, G, R, S

    localparam logic [EXP_W-1:0]    EXP_ONES = '1;
    localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [XW-1:0] X_ONE   = 1;
    localparam logic signed [XW-1:0] X_EMAX  = {2'b00, EXP_ONES};
    localparam logic [XW-1:0]       AW_X     = XW'(AW);

    logic r1_valid, r2_valid, r3_valid;
    logic w_adv;

    // The whole pipe freezes only while a result waits on the output.
    assign w_adv        = ~(r3_valid & ~bus.out_ready);
    assign bus.in_ready = w_adv;

    // ---------------- S1: classify, order by magnitude, align ----------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf;
    logic             w_a_big;
    logic [EXP_W-1:0] w_e_big, w_e_small;
    logic [MAN_W-1:0] w_f_big, w_f_small;
    logic signed [XW-1:0] w_xe_big, w_xe_small;
    logic [XW-1:0]    w_diff;
    logic [MAN_W:0]   w_m_big, w_m_small;
    logic [2*AW-1:0]  w_wide;
    logic [AW-1:0]    w_al;
    logic             w_al_stk;
    logic             w_spec, w_spec_inv;
    logic [W-1:0]     w_spec_val;

    assign {w_sa, w_ea, w_fa} = bus.a;
    assign w_sb = bus.b[W-1] ^ bus.sub;
    assign w_eb = bus.b[W-2:MAN_W];
    assign w_fb = bus.b[MAN_W-1:0];

    assign w_a_nan  = (w_ea == EXP_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == EXP_ONES) && (w_fb != '0);
    assign w_a_snan = w_a_nan & ~w_fa[MAN_W-1];
    assign w_b_snan = w_b_nan & ~w_fb[MAN_W-1];
    assign w_a_inf  = (w_ea == EXP_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == EXP_ONES) && (w_fb == '0);

    assign w_a_big   = bus.a[W-2:0] >= bus.b[W-2:0];
    assign w_e_big   = w_a_big ? w_ea : w_eb;
    assign w_f_big   = w_a_big ? w_fa : w_fb;
    assign w_e_small = w_a_big ? w_eb : w_ea;
    assign w_f_small = w_a_big ? w_fb : w_fa;

    // Subnormals behave as exponent 1 with a clear hidden bit.
    assign w_xe_big   = (w_e_big == '0)   ? X_ONE : $signed({2'b00, w_e_big});
    assign w_xe_small = (w_e_small == '0) ? X_ONE : $signed({2'b00, w_e_small});
    assign w_diff     = w_xe_big - w_xe_small;
    assign w_m_big    = {(w_e_big != '0), w_f_big};
    assign w_m_small  = {(w_e_small != '0), w_f_small};

    always_comb begin
        w_wide   = '0;
        w_al     = '0;
        w_al_stk = 1'b0;
        if (w_diff >= AW_X) begin
            w_al_stk = (w_m_small != '0);
        end else begin
            w_wide   = {w_m_small, 2'b00, {AW{1'b0}}} >> w_diff;
            w_al     = w_wide[2*AW-1:AW];
            w_al_stk = |w_wide[AW-1:0];
        end
    end

    always_comb begin
        w_spec     = 1'b0;
        w_spec_inv = 1'b0;
        w_spec_val = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec     = 1'b1;
            w_spec_val = QNAN;
            w_spec_inv = w_a_snan | w_b_snan;
        end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
            w_spec     = 1'b1;
            w_spec_val = QNAN;
            w_spec_inv = 1'b1;
        end else if (w_a_inf) begin
            w_spec     = 1'b1;
            w_spec_val = {w_sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_b_inf) begin
            w_spec     = 1'b1;
            w_spec_val = {w_sb, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    logic                 r1_spec, r1_spec_inv, r1_sign, r1_eff_sub, r1_stk;
    logic [W-1:0]         r1_spec_val;
    logic signed [XW-1:0] r1_exp;
    logic [MAN_W:0]       r1_m_big;
    logic [AW-1:0]        r1_m_small;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid    <= 1'b0;
            r1_spec     <= 1'b0;
            r1_spec_inv <= 1'b0;
            r1_spec_val <= '0;
            r1_sign     <= 1'b0;
            r1_eff_sub  <= 1'b0;
            r1_exp      <= '0;
            r1_m_big    <= '0;
            r1_m_small  <= '0;
            r1_stk      <= 1'b0;
        end else if (w_adv) begin
            r1_valid    <= bus.in_valid;
            r1_spec     <= w_spec;
            r1_spec_inv <= w_spec_inv;
            r1_spec_val <= w_spec_val;
            r1_sign     <= w_a_big ? w_sa : w_sb;
            r1_eff_sub  <= w_sa ^ w_sb;
            r1_exp      <= w_xe_big;
            r1_m_big    <= w_m_big;
            r1_m_small  <= w_al;
            r1_stk      <= w_al_stk;
        end
    end

    // ---------------- S2: magnitude add/sub and normalise ----------------
    logic [MW:0]          w_big_x, w_small_x, w_sum;
    logic [MW-1:0]        w_mag, w_norm;
    logic signed [XW-1:0] w_lzc, w_lim, w_shift, w_exp2;
    logic                 w_sign2;

    assign w_big_x   = {1'b0, r1_m_big, 3'b000};
    assign w_small_x = {1'b0, r1_m_small, r1_stk};
    assign w_sum     = r1_eff_sub ? (w_big_x - w_small_x) : (w_big_x + w_small_x);
    assign w_mag     = w_sum[MW-1:0];
    assign w_sign2   = (r1_eff_sub && (w_sum == '0)) ? 1'b0 : r1_sign;

    always_comb begin
        w_lzc = XW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (w_mag[i]) w_lzc = XW'(MW - 1 - i);
        end
    end

    // Left shift stops at exponent 1 so the result lands in the subnormal encoding.
    always_comb begin
        w_lim   = r1_exp - X_ONE;
        w_shift = '0;
        w_norm  = w_mag;
        w_exp2  = r1_exp;
        if (w_sum[MW]) begin
            w_norm = {w_sum[MW:2], w_sum[1] | w_sum[0]};
            w_exp2 = r1_exp + X_ONE;
        end else begin
            w_shift = (w_lzc > w_lim) ? w_lim : w_lzc;
            w_norm  = w_mag << w_shift;
            w_exp2  = r1_exp - w_shift;
        end
    end

    logic                 r2_spec, r2_spec_inv, r2_sign;
    logic [W-1:0]         r2_spec_val;
    logic signed [XW-1:0] r2_exp;
    logic [MW-1:0]        r2_mant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid    <= 1'b0;
            r2_spec     <= 1'b0;
            r2_spec_inv <= 1'b0;
            r2_spec_val <= '0;
            r2_sign     <= 1'b0;
            r2_exp      <= '0;
            r2_mant     <= '0;
        end else if (w_adv) begin
            r2_valid    <= r1_valid;
            r2_spec     <= r1_spec;
            r2_spec_inv <= r1_spec_inv;
            r2_spec_val <= r1_spec_val;
            r2_sign     <= w_sign2;
            r2_exp      <= w_exp2;
            r2_mant     <= w_norm;
        end
    end

    // ---------------- S3: round to nearest even and pack ----------------
    logic                 w_g, w_r, w_st, w_inc, w_inexact, w_ovf, w_unf;
    logic [MAN_W+1:0]     w_rnd;
    logic [MAN_W:0]       w_man3;
    logic signed [XW-1:0] w_exp3;
    logic [EXP_W-1:0]     w_pexp;
    logic [W-1:0]         w_res;
    logic [3:0]           w_flags;

    assign w_g       = r2_mant[2];
    assign w_r       = r2_mant[1];
    assign w_st      = r2_mant[0];
    assign w_inc     = w_g & (w_r | w_st | r2_mant[3]);
    assign w_rnd     = {1'b0, r2_mant[MW-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};
    assign w_man3    = w_rnd[MAN_W+1] ? w_rnd[MAN_W+1:1] : w_rnd[MAN_W:0];
    assign w_exp3    = w_rnd[MAN_W+1] ? (r2_exp + X_ONE) : r2_exp;
    assign w_inexact = w_g | w_r | w_st;
    assign w_ovf     = (w_exp3 >= X_EMAX);
    assign w_pexp    = w_man3[MAN_W] ? w_exp3[EXP_W-1:0] : '0;
    assign w_unf     = (w_pexp == '0) & w_inexact;

    always_comb begin
        w_res   = {r2_sign, w_pexp, w_man3[MAN_W-1:0]};
        w_flags = {2'b00, w_unf, w_inexact};
        if (r2_spec) begin
            w_res   = r2_spec_val;
            w_flags = {r2_spec_inv, 3'b000};
        end else if (w_ovf) begin
            w_res   = {r2_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_flags = 4'b0101;
        end
    end

    logic [W-1:0] r_s;
    logic [3:0]   r_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3_valid <= 1'b0;
            r_s      <= '0;
            r_flags  <= '0;
        end else if (w_adv) begin
            r3_valid <= r2_valid;
            r_s      <= r2_valid ? w_res : '0;
            r_flags  <= r2_valid ? w_flags : 4'b0000;
        end
    end

    assign bus.out_valid = r3_valid;
    assign bus.s         = r_s;
    assign bus.flags     = r_flags;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe in single precision: hand-computed vectors, latency,
// output stall and mid-flight reset, checked through an expected-result queue.
module tb_fp_addsub_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = EXP_W + MAN_W + 1;
    localparam int NV    = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_addsub_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int n_out = 0;
    logic [W+3:0] exp_q[$];

    logic [W-1:0] va[NV], vb[NV], vs[NV];
    logic         vsub[NV];
    logic [3:0]   vf[NV];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                           input logic sub_v, input logic [W-1:0] s_v, input logic [3:0] f_v);
        va[i] = a_v; vb[i] = b_v; vsub[i] = sub_v; vs[i] = s_v; vf[i] = f_v;
    endtask

    // Present one operation, wait (bounded) for acceptance, then push its expected result.
    task automatic send(input int i);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.a = va[i];
        bus.b = vb[i];
        bus.sub = vsub[i];
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) check_eq("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        exp_q.push_back({vs[i], vf[i]});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every emitted result must match the queue head; a held result must stay equal to it.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                if (bus.out_ready) check_eq("unexpected_out", 64'(bus.s), 64'hdead);
            end else if (bus.out_ready) begin
                check_eq("s", 64'(bus.s), 64'(exp_q[0][W+3:4]));
                check_eq("flags", 64'(bus.flags), 64'(exp_q[0][3:0]));
                void'(exp_q.pop_front());
                n_out++;
            end else begin
                check_eq("s_hold", 64'(bus.s), 64'(exp_q[0][W+3:4]));
                check_eq("flags_hold", 64'(bus.flags), 64'(exp_q[0][3:0]));
            end
        end
    end

    initial begin
        int out_before;
        int idx[6];

        set_vec(0,  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
        set_vec(1,  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        set_vec(2,  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        set_vec(3,  32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001);
        set_vec(4,  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        set_vec(5,  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
        set_vec(6,  32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000);
        set_vec(7,  32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        set_vec(8,  32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
        set_vec(9,  32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
        set_vec(10, 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
        set_vec(11, 32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'b0000);
        set_vec(12, 32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 4'b0000);
        set_vec(13, 32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'b0000);
        set_vec(14, 32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000);
        idx = '{2, 3, 4, 5, 6, 12};

        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_s", 64'(bus.s), 64'd0);
        check_eq("rst_flags", 64'(bus.flags), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency of a single operation
        send(0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_eq("latency", 64'(bus.out_valid), (k == 3) ? 64'd1 : 64'd0);
        end
        wait_drain();

        // Directed vectors streamed back-to-back
        for (int i = 1; i < NV; i++) send(i);
        wait_drain();
        @(negedge clk);
        check_eq("idle_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("idle_flags", 64'(bus.flags), 64'd0);
        @(posedge clk);
        #1;

        // Six operations with the output stalled for seven cycles
        out_before = n_out;
        fork
            begin
                for (int j = 0; j < 6; j++) send(idx[j]);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                for (int k = 0; k < 7; k++) begin
                    @(negedge clk);
                    check_eq("stall_in_ready", 64'(bus.in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        check_eq("stall_count", 64'(n_out - out_before), 64'd6);

        // Reset with three operations in flight
        bus.in_valid = 1'b1;
        bus.a = va[0];
        bus.b = vb[0];
        bus.sub = vsub[0];
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("post_rst_idle", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_eq("post_rst_latency", 64'(bus.out_valid), (k == 3) ? 64'd1 : 64'd0);
        end
        wait_drain();
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
